sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, address width; depth SHALL be 2^ADDR_WIDTH words (256 at default).
REQ-003 Parameter AFULL_LEVEL, default 248, almost-full threshold in words.
REQ-004 Parameter AEMPTY_LEVEL, default 8, almost-empty threshold in words.
REQ-005 Parameter LOOKAHEAD, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all logic rising-edge triggered.
REQ-007 rstb  input  1  reset, synchronous and active-high (1 = reset) despite the name.
REQ-008 sclr  input  1  synchronous clear, active-high.
REQ-009 wr_en  input  1  write request.
REQ-010 data_in  input  DATA_WIDTH  write data.
REQ-011 rd_en  input  1  read request.
REQ-012 data_out  output  DATA_WIDTH  read data.
REQ-013 empty  output  1  high when uw == 0.
REQ-014 full  output  1  high when uw == 2^ADDR_WIDTH.
REQ-015 afull  output  1  high when uw >= AFULL_LEVEL.
REQ-016 aempty  output  1  high when uw <= AEMPTY_LEVEL.
REQ-017 uw  output  ADDR_WIDTH+1  used-word count, 0 to 2^ADDR_WIDTH.

Function
REQ-018 Storage SHALL be a 2^ADDR_WIDTH x DATA_WIDTH memory with ADDR_WIDTH-bit write and read pointers that wrap modulo depth.
REQ-019 A write SHALL be accepted on a clock edge iff wr_en=1 and full=0: data_in is stored at the write pointer and the write pointer increments.
REQ-020 A read SHALL be accepted on a clock edge iff rd_en=1 and empty=0: the read pointer increments.
REQ-021 Writes while full and reads while empty SHALL be ignored, with no change to pointers, uw, memory or data_out.
REQ-022 uw SHALL be a register: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write or on neither.
REQ-023 Acceptance SHALL use the flag values before the edge: when empty with both requests, only the write is accepted; when full with both requests, only the read is accepted.
REQ-024 All flags SHALL be combinational decodes of the registered uw, so they update in the same cycle uw changes.
REQ-025 LOOKAHEAD=0: on an accepted read, data_out SHALL register the word at the read pointer; data is valid the cycle after the rd_en edge and SHALL hold until the next accepted read.
REQ-026 LOOKAHEAD=1: data_out SHALL continuously show the word at the read pointer. The oldest word appears the cycle after it is written into an empty FIFO, and the next word appears the cycle after an accepted read. data_out is don't-care while empty.
REQ-027 Data SHALL emerge in write order (FIFO ordering) across pointer wrap-around.
REQ-028 sclr=1 SHALL, on the clock edge, zero both pointers and uw, and zero data_out in LOOKAHEAD=0 mode. Any wr_en/rd_en in that cycle SHALL be ignored. Memory contents need not be cleared.

Reset
REQ-029 rstb=1 at a clock edge SHALL force pointers=0, uw=0, data_out=0 (LOOKAHEAD=0), so that empty=1, aempty=1, full=0, afull=0.
REQ-030 rstb SHALL have priority over sclr, and sclr over wr_en/rd_en. Reset mid-operation SHALL discard all stored words.

Verification
REQ-031 Reset, then write 16 random words on consecutive cycles -> uw steps 1..16; empty falls after first write; aempty falls when uw=9; full/afull stay 0.
REQ-032 Idle 10 cycles, write 16 more words -> uw=32; then with LOOKAHEAD=0 assert rd_en 16 cycles, idle 10, rd_en 16 cycles -> data_out shows all 32 words in write order, each one cycle after its rd_en edge; uw ends 0, empty=1, aempty=1.
REQ-033 Write 256 words with no reads -> afull rises at uw=248, full rises at uw=256; a 257th write is ignored (uw stays 256, stored data intact).
REQ-034 rd_en asserted while empty -> uw stays 0, data_out unchanged. Simultaneous wr_en+rd_en at uw=5 -> uw stays 5 and the read returns the oldest word.
REQ-035 With uw=20, pulse sclr with wr_en=1 -> next cycle uw=0, empty=1; a subsequent write/read returns the newly written word.
REQ-036 LOOKAHEAD=1: write one word into an empty FIFO -> data_out equals it the next cycle without rd_en; a read then advances data_out to the following word.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with used-word count and full/empty/
// almost-full/almost-empty flags. LOOKAHEAD selects a registered read
// port (0) or a first-word-fall-through read port (1).
module sync_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int AFULL_LEVEL  = 248,
    parameter int AEMPTY_LEVEL = 8,
    parameter int LOOKAHEAD    = 0
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  sclr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  afull,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   uw
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   UW_ZERO   = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   UW_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   UW_DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   uw_r;

    logic empty_s;
    logic full_s;
    logic afull_s;
    logic aempty_s;
    logic wr_acc_s;
    logic rd_acc_s;

    // Flag decode from the registered count, and request acceptance
    // qualified by the pre-edge flags.
    always_comb begin
        empty_s  = (uw_r == UW_ZERO);
        full_s   = (uw_r == UW_DEPTH);
        afull_s  = (32'(uw_r) >= 32'(AFULL_LEVEL));
        aempty_s = (32'(uw_r) <= 32'(AEMPTY_LEVEL));
        wr_acc_s = wr_en && !full_s;
        rd_acc_s = rd_en && !empty_s;
    end

    assign empty  = empty_s;
    assign full   = full_s;
    assign afull  = afull_s;
    assign aempty = aempty_s;
    assign uw     = uw_r;

    // Storage write; contents are left untouched by reset and clear.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !rstb && !sclr) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointer and used-word bookkeeping; reset beats clear beats traffic.
    always_ff @(posedge clk) begin
        if (rstb) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            uw_r     <= UW_ZERO;
        end else if (sclr) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            uw_r     <= UW_ZERO;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   uw_r <= uw_r + UW_ONE;
                2'b01:   uw_r <= uw_r - UW_ONE;
                default: uw_r <= uw_r;
            endcase
        end
    end

    generate
        if (LOOKAHEAD == 0) begin : g_registered
            logic [DATA_WIDTH-1:0] dout_r;

            // Registered read port: capture the head word on each accepted read.
            always_ff @(posedge clk) begin
                if (rstb) begin
                    dout_r <= DATA_ZERO;
                end else if (sclr) begin
                    dout_r <= DATA_ZERO;
                end else if (rd_acc_s) begin
                    dout_r <= mem_r[rd_ptr_r];
                end
            end

            assign data_out = dout_r;
        end else begin : g_fwft
            // Fall-through read port: the head word is always visible.
            assign data_out = mem_r[rd_ptr_r];
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives one registered-read and one fall-through FIFO with
// identical stimulus and checks both against a queue-based model every cycle.
module tb_sync_fifo;

    logic        clk;
    logic        rstb;
    logic        sclr;
    logic        wr_en;
    logic [31:0] data_in;
    logic        rd_en;

    logic [31:0] dout0, dout1;
    logic        empty0, full0, afull0, aempty0;
    logic        empty1, full1, afull1, aempty1;
    logic [8:0]  uw0, uw1;

    sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .AFULL_LEVEL(248),
                .AEMPTY_LEVEL(8), .LOOKAHEAD(0)) u_dut0 (
        .clk(clk), .rstb(rstb), .sclr(sclr), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout0), .empty(empty0), .full(full0),
        .afull(afull0), .aempty(aempty0), .uw(uw0));

    sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .AFULL_LEVEL(248),
                .AEMPTY_LEVEL(8), .LOOKAHEAD(1)) u_dut1 (
        .clk(clk), .rstb(rstb), .sclr(sclr), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout1), .empty(empty1), .full(full1),
        .afull(afull1), .aempty(aempty1), .uw(uw1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents in write order plus the registered-port output.
    logic [31:0] q[$];
    logic [31:0] exp_dout0;
    int          n_checks;
    int          n_fail;
    logic        chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("uw0",     32'(uw0),     32'(q.size()));
            check("uw1",     32'(uw1),     32'(q.size()));
            check("empty0",  32'(empty0),  32'(q.size() == 0));
            check("empty1",  32'(empty1),  32'(q.size() == 0));
            check("full0",   32'(full0),   32'(q.size() == 256));
            check("full1",   32'(full1),   32'(q.size() == 256));
            check("afull0",  32'(afull0),  32'(q.size() >= 248));
            check("afull1",  32'(afull1),  32'(q.size() >= 248));
            check("aempty0", 32'(aempty0), 32'(q.size() <= 8));
            check("aempty1", 32'(aempty1), 32'(q.size() <= 8));
            check("dout0",   dout0,        exp_dout0);
            if (q.size() > 0) begin
                check("dout1", dout1, q[0]);
            end
        end
    end

    // One clock with the given inputs; the model advances on the same edge.
    task automatic tick(input logic w, input logic [31:0] d, input logic r,
                        input logic s, input logic rb);
        logic wa, ra;
        wr_en = w; data_in = d; rd_en = r; sclr = s; rstb = rb;
        @(posedge clk);
        if (rb || s) begin
            q.delete();
            exp_dout0 = 32'd0;
        end else begin
            wa = w && (q.size() < 256);
            ra = r && (q.size() > 0);
            if (ra) begin
                exp_dout0 = q.pop_front();
            end
            if (wa) begin
                q.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    logic [31:0] words [0:31];
    logic [31:0] tmp;
    logic [31:0] first5;

    initial begin
        n_checks = 0; n_fail = 0; chk_en = 1'b0; exp_dout0 = 32'd0;
        rstb = 1'b1; sclr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 32'd0;

        // Reset state
        tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("rst_uw",     32'(uw0),     32'd0);
        check("rst_empty",  32'(empty0),  32'd1);
        check("rst_aempty", 32'(aempty0), 32'd1);
        check("rst_full",   32'(full0),   32'd0);
        check("rst_afull",  32'(afull0),  32'd0);
        check("rst_dout0",  dout0,        32'd0);

        // 16 consecutive writes, then idle, then 16 more
        for (int i = 0; i < 16; i++) begin
            words[i] = $urandom;
            tick(1'b1, words[i], 1'b0, 1'b0, 1'b0);
            check("fill_uw", 32'(uw0), 32'(i + 1));
            if (i == 0) check("empty_fall", 32'(empty0), 32'd0);
            if (i == 7) check("aempty_at8", 32'(aempty0), 32'd1);
            if (i == 8) check("aempty_at9", 32'(aempty0), 32'd0);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 16; i < 32; i++) begin
            words[i] = $urandom;
            tick(1'b1, words[i], 1'b0, 1'b0, 1'b0);
        end
        check("uw_32", 32'(uw0), 32'd32);

        // Read back in two bursts separated by idle cycles
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            check("burst_a", dout0, words[i]);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("hold_dout", dout0, words[15]);
        for (int i = 16; i < 32; i++) begin
            tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            check("burst_b", dout0, words[i]);
        end
        check("drained_uw",    32'(uw0),     32'd0);
        check("drained_empty", 32'(empty0),  32'd1);

        // Read while empty is ignored
        for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("rd_empty_dout", dout0, words[31]);
        check("rd_empty_uw",   32'(uw0), 32'd0);

        // Simultaneous read and write at uw=5
        for (int i = 0; i < 5; i++) begin
            tmp = $urandom;
            if (i == 0) first5 = tmp;
            tick(1'b1, tmp, 1'b0, 1'b0, 1'b0);
        end
        tick(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        check("rw_uw",   32'(uw0), 32'd5);
        check("rw_dout", dout0,    first5);
        for (int i = 0; i < 5; i++) tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Fill to full, overflow attempt, then drain everything
        for (int i = 0; i < 256; i++) tick(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        check("full_uw",    32'(uw0),   32'd256);
        check("full_flag",  32'(full0), 32'd1);
        tick(1'b1, 32'hdeadbeef, 1'b0, 1'b0, 1'b0);
        check("overflow_uw", 32'(uw0), 32'd256);
        for (int i = 0; i < 256; i++) tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("empty_again", 32'(empty0), 32'd1);

        // Clear with a concurrent write at uw=20
        for (int i = 0; i < 20; i++) tick(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0);
        check("sclr_uw",    32'(uw0),    32'd0);
        check("sclr_empty", 32'(empty0), 32'd1);
        check("sclr_dout0", dout0,       32'd0);
        tmp = $urandom;
        tick(1'b1, tmp, 1'b0, 1'b0, 1'b0);
        check("fwft_first", dout1, tmp);
        first5 = $urandom;
        tick(1'b1, first5, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("after_clr_read", dout0, tmp);
        check("fwft_advance",   dout1, first5);

        // Randomized traffic alternating fill-biased and drain-biased phases
        for (int i = 0; i < 4000; i++) begin
            logic w, r;
            if (((i / 400) % 2) == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            tick(w, $urandom, r, ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 799) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
